// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-consumer bus of the UART receive FIFO: write strobe, pop request,
// overrun clear and the FIFO status outputs.
interface uart_rx_fifo_if #(
  parameter int AW = 4
);
  logic [7:0]  rx_data_i;
  logic        rx_ack_i;
  logic        rd_en_i;
  logic        ovr_clr_i;
  logic [7:0]  rd_data_o;
  logic        empty_o;
  logic        full_o;
  logic        hwm_o;
  logic [AW:0] count_o;
  logic        overrun_o;

  modport master (
    output rx_data_i, rx_ack_i, rd_en_i, ovr_clr_i,
    input  rd_data_o, empty_o, full_o, hwm_o, count_o, overrun_o
  );

  modport slave (
    input  rx_data_i, rx_ack_i, rd_en_i, ovr_clr_i,
    output rd_data_o, empty_o, full_o, hwm_o, count_o, overrun_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: one write per rising edge of the receiver strobe, first-word
// fall-through read port, high-water flag and sticky overrun on dropped bytes.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int HWM   = 12
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  uart_rx_fifo_if.slave  bus
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] HWM_CNT  = (AW+1)'(HWM);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ack_q;
  logic          overrun;

  logic wr;
  logic pop;
  logic full;
  logic wr_ok;
  logic drop;

  // ack_q resets to 1 so a strobe already high at reset release is not a new frame
  assign wr    = bus.rx_ack_i & ~ack_q;
  assign full  = (count == FULL_CNT);
  assign pop   = bus.rd_en_i & (count != '0);
  assign wr_ok = wr & (~full | pop);
  assign drop  = wr & full & ~pop;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_q   <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      ack_q <= bus.rx_ack_i;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // a drop in the same cycle as a clear keeps the flag set
      if (drop)               overrun <= 1'b1;
      else if (bus.ovr_clr_i) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_ptr] <= bus.rx_data_i;
  end

  assign bus.rd_data_o = mem[rd_ptr];
  assign bus.count_o   = count;
  assign bus.empty_o   = (count == '0);
  assign bus.full_o    = full;
  assign bus.hwm_o     = (count >= HWM_CNT);
  assign bus.overrun_o = overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: vector table for single-byte traffic plus queue-scoreboard
// sequences for wrap, full/overrun, simultaneous read/write, flags and reset.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int HWM   = 12;

  logic clk;
  logic rst_n;

  uart_rx_fifo_if #(.AW(AW)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .HWM(HWM)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  logic       m_ack;
  logic       m_ovr;
  logic [7:0] last_pop;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ack = 1'b1;
    m_ovr = 1'b0;
  endtask

  // Drive one cycle of inputs, check the head byte on pops, update the model at
  // the edge and compare all status outputs just after it.
  task automatic step(input logic ack, input logic [7:0] d, input logic rd, input logic clr);
    logic m_wr, m_pop, m_full, m_drop;
    bus.rx_ack_i  = ack;
    bus.rx_data_i = d;
    bus.rd_en_i   = rd;
    bus.ovr_clr_i = clr;
    @(negedge clk);
    m_wr   = ack & ~m_ack;
    m_pop  = rd & (sb.size() != 0);
    m_full = (sb.size() == DEPTH);
    m_drop = m_wr & m_full & ~m_pop;
    if (m_pop) begin
      chk("pop_data", int'(bus.rd_data_o), int'(sb[0]));
      last_pop = sb.pop_front();
    end
    if (m_wr && !m_drop) sb.push_back(d);
    if (m_drop)   m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    m_ack = ack;
    @(posedge clk);
    #1;
    chk("count", int'(bus.count_o), sb.size());
    chk("empty", int'(bus.empty_o), int'(sb.size() == 0));
    chk("full", int'(bus.full_o), int'(sb.size() == DEPTH));
    chk("hwm", int'(bus.hwm_o), int'(sb.size() >= HWM));
    chk("overrun", int'(bus.overrun_o), int'(m_ovr));
    if (sb.size() != 0) chk("head", int'(bus.rd_data_o), int'(sb[0]));
  endtask

  task automatic drain();
    for (int k = 0; k < 2*DEPTH && sb.size() != 0; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drained", int'(bus.empty_o), 1);
  endtask

  typedef struct {
    logic       ack;
    logic [7:0] data;
    logic       rd;
    int         exp_cnt;
    logic [7:0] exp_head;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 0, 8'h00};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1, 8'hA5};
    vecs[2]  = '{1'b1, 8'hA5, 1'b0, 1, 8'hA5};
    vecs[3]  = '{1'b1, 8'hA5, 1'b0, 1, 8'hA5};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 0, 8'h00};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 0, 8'h00};
    vecs[6]  = '{1'b1, 8'h66, 1'b1, 1, 8'h66};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 0, 8'h00};
    vecs[8]  = '{1'b1, 8'h3C, 1'b0, 1, 8'h3C};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1, 8'h3C};
    vecs[10] = '{1'b1, 8'h3D, 1'b0, 2, 8'h3C};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1, 8'h3D};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 0, 8'h00};

    rst_n = 1'b0;
    bus.rx_ack_i  = 1'b0;
    bus.rx_data_i = 8'h00;
    bus.rd_en_i   = 1'b0;
    bus.ovr_clr_i = 1'b0;
    model_reset();
    last_pop = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(bus.count_o), 0);
    chk("rst_empty", int'(bus.empty_o), 1);
    chk("rst_full", int'(bus.full_o), 0);
    chk("rst_hwm", int'(bus.hwm_o), 0);
    chk("rst_overrun", int'(bus.overrun_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].ack, vecs[i].data, vecs[i].rd, 1'b0);
      chk("vec_count", int'(bus.count_o), vecs[i].exp_cnt);
      if (vecs[i].exp_cnt != 0) chk("vec_head", int'(bus.rd_data_o), int'(vecs[i].exp_head));
    end

    // ordered traffic with pointer wrap
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 8'(i), (i >= 8), 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    drain();
    chk("wrap_last", int'(last_pop), 8'h17);
    chk("wrap_ovr", int'(bus.overrun_o), 0);

    // fill past full
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("ovf_full", int'(bus.full_o), 1);
    chk("ovf_count", int'(bus.count_o), 16);
    chk("ovf_overrun", int'(bus.overrun_o), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovr_clear", int'(bus.overrun_o), 0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("ovr_set_wins", int'(bus.overrun_o), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovr_clear2", int'(bus.overrun_o), 0);
    chk("full_head", int'(bus.rd_data_o), 8'h10);

    // write and pop together while full
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("sim_full_count", int'(bus.count_o), 16);
    chk("sim_full_ovr", int'(bus.overrun_o), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();
    chk("sim_last", int'(last_pop), 8'h55);

    // write and pop together while empty
    step(1'b1, 8'h66, 1'b1, 1'b0);
    chk("sim_empty_count", int'(bus.count_o), 1);
    chk("sim_empty_data", int'(bus.rd_data_o), 8'h66);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    // high-water threshold
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("hwm_11", int'(bus.hwm_o), 0);
    step(1'b1, 8'h8B, 1'b0, 1'b0);
    chk("hwm_12", int'(bus.hwm_o), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rd_empty_count", int'(bus.count_o), 0);

    // reset in mid-cycle with strobe held high across release
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("pre_rst_count", int'(bus.count_o), 5);
    #2;
    rst_n = 1'b0;
    bus.rx_ack_i  = 1'b1;
    bus.rx_data_i = 8'h77;
    #1;
    chk("arst_count", int'(bus.count_o), 0);
    chk("arst_empty", int'(bus.empty_o), 1);
    chk("arst_full", int'(bus.full_o), 0);
    chk("arst_hwm", int'(bus.hwm_o), 0);
    chk("arst_overrun", int'(bus.overrun_o), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    chk("rel_no_write", int'(bus.count_o), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h88, 1'b0, 1'b0);
    chk("rel_new_write", int'(bus.count_o), 1);
    chk("rel_new_data", int'(bus.rd_data_o), 8'h88);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, 16, FIFO entries; power of two, 2..256.
REQ-002 Parameter AW, 4, address width, log2(DEPTH).
REQ-003 Parameter HWM, 12, high-water threshold, 1..DEPTH.
REQ-004 clk_i  input  1  single clock for all state.
REQ-005 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 rx_data_i  input  8  received byte from receiver stage, valid while rx_ack_i high.
REQ-007 rx_ack_i  input  1  receiver frame-done strobe, may stay high more than one cycle.
REQ-008 rd_en_i  input  1  consumer pop request.
REQ-009 ovr_clr_i  input  1  clears sticky overrun flag.
REQ-010 rd_data_o  output  8  head-of-FIFO byte, valid while empty_o low.
REQ-011 empty_o  output  1  FIFO holds zero bytes.
REQ-012 full_o  output  1  FIFO holds DEPTH bytes.
REQ-013 hwm_o  output  1  count >= HWM.
REQ-014 count_o  output  AW+1  bytes stored, 0..DEPTH.
REQ-015 overrun_o  output  1  sticky: a byte was dropped because FIFO was full.

Function
REQ-016 All state SHALL update on the rising edge of clk_i only.
REQ-017 Block SHALL register rx_ack_i into ack_q; write strobe wr = rx_ack_i & ~ack_q (one write per strobe, however long held).
REQ-018 On wr, rx_data_i SHALL be sampled in that same cycle.
REQ-019 Pop SHALL occur when rd_en_i high and empty_o low; rd_en_i while empty SHALL be ignored, no state change.
REQ-020 rd_data_o SHALL be mem[rd_ptr] combinationally (first-word fall-through); value when empty is don't-care.
REQ-021 Write latency: byte sampled at edge N SHALL appear on rd_data_o with empty_o low after edge N (visible in cycle N+1).
REQ-022 wr_ptr and rd_ptr SHALL be AW bits, increment by 1, wrap DEPTH-1 -> 0.
REQ-023 count_o SHALL be +1 on accepted write only, -1 on pop only, unchanged on both or neither.
REQ-024 empty_o = (count_o == 0); full_o = (count_o == DEPTH); hwm_o = (count_o >= HWM); all derived from registered count.
REQ-025 wr while full and no pop: byte SHALL be dropped, pointers/count unchanged, overrun_o set at next edge.
REQ-026 wr and pop in same cycle while full: both SHALL proceed, count stays DEPTH, overrun_o unaffected.
REQ-027 wr and rd_en_i in same cycle while empty: write proceeds, pop ignored, count becomes 1.
REQ-028 ovr_clr_i SHALL clear overrun_o at next edge; if a drop occurs in the same cycle, set wins.
REQ-029 Memory contents SHALL not be reset; only pointers, count, ack_q, overrun_o.

Reset
REQ-030 rst_n_i low SHALL immediately (asynchronously) force wr_ptr=0, rd_ptr=0, count_o=0, ack_q=1, overrun_o=0.
REQ-031 During reset outputs SHALL be empty_o=1, full_o=0, hwm_o=0, overrun_o=0, count_o=0.
REQ-032 ack_q reset to 1 SHALL prevent a write if rx_ack_i is already high when reset releases.
REQ-033 Reset asserted mid-operation SHALL discard all stored bytes; no write or pop occurs on the release edge unless a new strobe rises after release.

Verification
REQ-034 Single byte: rx_data_i=0xA5, rx_ack_i high 3 cycles -> count_o=1, rd_data_o=0xA5, empty_o=0 from next cycle; one pulse of rd_en_i -> empty_o=1, count_o=0.
REQ-035 Order/wrap: write 0x00..0x17 interleaved with pops keeping count <=16 -> bytes read back 0x00..0x17 in order, pointers wrap, no overrun.
REQ-036 Full/overrun: 17 strobes 0x10..0x20, no pops -> full_o=1, count_o=16, overrun_o=1, reads return 0x10..0x1F; 0x20 never appears; ovr_clr_i pulse -> overrun_o=0.
REQ-037 Simultaneous: full, strobe 0x55 with rd_en_i -> count_o stays 16, overrun_o=0, 0x55 read last; empty, strobe 0x66 with rd_en_i -> count_o=1, rd_data_o=0x66.
REQ-038 Flags: after 12 writes hwm_o=1, after 11 hwm_o=0; rd_en_i on empty FIFO -> count_o stays 0.
REQ-039 Reset: 5 bytes stored, rst_n_i low mid-cycle -> outputs reset values immediately; rx_ack_i held high across release -> no write, count_o=0.
